// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter feeding CP0's external interrupt input.
// Synchronises and edge-latches N lines, masks them and sequences one request at a time.
module irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_irq_src,
  input  logic             i_mask_we,
  input  logic [N_SRC-1:0] i_mask_wdata,
  input  logic [N_SRC-1:0] i_pend_clr,
  input  logic             i_ir_take,
  input  logic             i_eret,
  output logic             o_ir_out,
  output logic             o_cause_valid,
  output logic [IDX_W-1:0] o_cause_idx,
  output logic [N_SRC-1:0] o_mask,
  output logic [N_SRC-1:0] o_pending
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [N_SRC-1:0] r_s1;
  logic [N_SRC-1:0] r_s2;
  logic [N_SRC-1:0] r_s3;
  logic [N_SRC-1:0] r_arm;
  logic             r_v1;
  logic             r_v2;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_cause_idx;
  logic             r_ir_out;
  logic             r_cause_valid;

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_take_clr;
  logic [N_SRC-1:0] w_pending_next;
  logic [N_SRC-1:0] w_eligible;
  logic             w_any;
  logic [IDX_W-1:0] w_win_idx;
  logic [1:0]       w_state_next;
  logic [IDX_W-1:0] w_idx_next;

  // A line is armed only once its synchronised value has been seen low after
  // reset, so a line held high across reset cannot fake a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_arm <= '0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
    end else begin
      r_s1  <= i_irq_src;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_arm <= r_arm | ({N_SRC{r_v2}} & ~r_s2);
      r_v1  <= 1'b1;
      r_v2  <= r_v1;
    end
  end

  assign w_edge     = r_s2 & ~r_s3 & r_arm;
  assign w_eligible = r_pending & r_mask;
  assign w_any      = |w_eligible;

  // Set has priority over clear, so an edge coincident with a clear survives.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
      assign w_take_clr[gi] = (r_state == ST_REQ) && i_ir_take &&
                              (r_cause_idx == IDX_W'(gi));
      assign w_pending_next[gi] = w_edge[gi] |
                                  (r_pending[gi] & ~(i_pend_clr[gi] | w_take_clr[gi]));
    end
  endgenerate

  always_comb begin
    w_win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_win_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_cause_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next = ST_REQ;
          w_idx_next   = w_win_idx;
        end
      end
      ST_REQ: begin
        if (i_ir_take) begin
          w_state_next = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (i_eret) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= '0;
      r_mask        <= '0;
      r_state       <= ST_IDLE;
      r_cause_idx   <= '0;
      r_ir_out      <= 1'b0;
      r_cause_valid <= 1'b0;
    end else begin
      r_pending     <= w_pending_next;
      if (i_mask_we) begin
        r_mask <= i_mask_wdata;
      end
      r_state       <= w_state_next;
      r_cause_idx   <= w_idx_next;
      r_ir_out      <= (w_state_next == ST_REQ);
      r_cause_valid <= (w_state_next != ST_IDLE);
    end
  end

  assign o_ir_out      = r_ir_out;
  assign o_cause_valid = r_cause_valid;
  assign o_cause_idx   = r_cause_idx;
  assign o_mask        = r_mask;
  assign o_pending     = r_pending;

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Multi-source interrupt controller in front of the CP0 unit.
- Synchronises N asynchronous interrupt lines, latches their rising edges into a pending register and applies a software-writable enable mask.
- Selects the highest-priority pending source (lowest index) and presents it as a single edge-style request to CP0's external interrupt input.
- Sequences request / acceptance / ERET so that exactly one interrupt is in service at a time, and exposes the in-service cause index.

Parameters:
- N_SRC, 8, number of interrupt sources (2..32).
- IDX_W, 3, width of cause index; must satisfy 2**IDX_W >= N_SRC.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- irq_src  in  N_SRC  asynchronous interrupt lines, rising-edge significant
- mask_we  in  1  write enable for mask register
- mask_wdata  in  N_SRC  new mask value (1 = source enabled)
- pend_clr  in  N_SRC  write-1-to-clear pulses for pending bits
- ir_take  in  1  CP0 has vectored to the handler for the current request (one-cycle pulse)
- eret  in  1  ERET executed in CP0 (one-cycle pulse)
- ir_out  out  1  request to CP0 external interrupt input
- cause_valid  out  1  a source is requested or in service
- cause_idx  out  IDX_W  index of the requested / in-service source
- mask  out  N_SRC  current mask register
- pending  out  N_SRC  current pending register

Behaviour:
- Reset values: all sync flops 0, pending 0, mask 0, state IDLE, ir_out 0, cause_valid 0, cause_idx 0. Reset in any state aborts immediately, with no residual request.
- Synchroniser: two flops per line, plus a third flop for edge detection. The edge is s2 & ~s3.
- Pending update, per bit, each cycle, in priority order:
  - edge detected -> set;
  - else pend_clr bit or take-clear (see REQ) -> clear;
  - else hold.
  - An edge coincident with a clear therefore leaves the bit set.
- Mask: mask_we loads mask_wdata at the clock edge. The new value affects arbitration from the next cycle.
- Eligible vector = pending & mask. Winner = lowest set index.
- FSM, registered state and outputs:
  - IDLE: ir_out 0, cause_valid 0. If eligible != 0, latch winner into cause_idx -> REQ.
  - REQ: ir_out 1, cause_valid 1. cause_idx is frozen; later mask or pending changes do not re-arbitrate or cancel.
    - On ir_take: clear pending[cause_idx] -> SERVICE.
    - pend_clr of the latched bit while in REQ does not cancel the request.
  - SERVICE: ir_out 0, cause_valid 1, cause_idx held. New edges still set pending. On eret -> IDLE.
- Ignored pulses: ir_take in IDLE/SERVICE and eret in IDLE/REQ.
- ir_take and eret in the same cycle in REQ: ir_take is honoured -> SERVICE; that eret is discarded.
- Minimum spacing: ir_out is low for at least one IDLE cycle between consecutive requests, so CP0's edge detector sees a fresh rising edge.
- Latency: with irq_src high before clock edge E0 and the source enabled in IDLE:
  - pending bit visible after E2;
  - state REQ and ir_out = 1 after E3.
- Nesting: none; while in REQ/SERVICE, further sources only accumulate in pending.
- Widths: all vectors are N_SRC bits. cause_idx is zero-extended into IDX_W.

Test Plan:
1. Reset, mask=0xFF, pulse irq_src[5] high for 3 cycles -> pending=0x20 after E2; ir_out=1, cause_idx=5 after E3. Pulse ir_take -> pending=0x00, ir_out=0, cause_valid=1. Pulse eret -> IDLE, cause_valid=0.
2. mask=0x0C; raise irq_src[1], [3] and [2] in the same cycle -> pending=0x0E, cause_idx=2. Take + eret -> one IDLE cycle with ir_out=0, then ir_out=1 with cause_idx=3. Bit 1 stays pending and never requests.
3. In SERVICE of source 3, new edge on src 0 -> pending[0]=1, ir_out stays 0. After eret -> IDLE one cycle, then REQ with cause_idx=0.
4. In REQ for source 4: write mask=0x00 and pend_clr=0x10 -> ir_out stays 1, cause_idx=4. ir_take -> SERVICE normally.
5. Edge on src 6 in the same cycle as ir_take for cause 6 -> pending[6] remains 1, so a second request with cause_idx=6 follows after eret.
6. Assert rst during REQ and during SERVICE -> next cycle: ir_out=0, cause_valid=0, pending=0, mask=0. A held-high irq_src after reset produces no edge until it falls and rises again.
